// File: rtl/data_memory_ctrl_if.sv
// Bus between the MEM stage (master) and the data memory controller (slave).
// Handshake: a request transfers on a rising edge where req && ready; the
// master holds we/size/sext/addr/wdata stable while req is high, and the
// slave answers a load with a one-cycle rvalid pulse (or a one-cycle misalign
// pulse for a bad access) in the cycle after the transfer.
interface data_memory_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic              clear;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              misalign;

    modport master (
        output req, we, size, sext, addr, wdata, clear,
        input  ready, rvalid, rdata, misalign
    );

    modport slave (
        input  req, we, size, sext, addr, wdata, clear,
        output ready, rvalid, rdata, misalign
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed single-port data memory for the MEM stage: byte/half/word
// loads and stores, sign/zero extension, misalignment reporting and a
// sequential clear sweep so the array itself never needs a reset.
module data_memory_ctrl #(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    data_memory_ctrl_if.slave   bus,
    output logic [0:0]          dbg_state
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              err;
    logic              do_store;
    logic              do_load;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        off;
    logic [3:0]        lane_en;
    logic [31:0]       wword;
    logic [31:0]       rword;
    logic [31:0]       rext;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;

    assign widx      = bus.addr[ADDR_W+1:2];
    assign off       = bus.addr[1:0];
    assign accept    = bus.req && bus.ready;
    assign do_store  = accept && bus.we && !err;
    assign do_load   = accept && !bus.we && !err;
    assign dbg_state = state;

    // Flag reserved sizes and accesses not aligned to their natural size.
    always_comb begin
        err = 1'b0;
        case (bus.size)
            2'b00:   err = 1'b0;
            2'b01:   err = off[0];
            2'b10:   err = (off != 2'b00);
            default: err = 1'b1;
        endcase
    end

    // Replicate store data across lanes and pick the lanes to update.
    always_comb begin
        lane_en = 4'b0000;
        wword   = bus.wdata;
        case (bus.size)
            2'b00: begin
                wword   = {4{bus.wdata[7:0]}};
                lane_en = 4'b0001 << off;
            end
            2'b01: begin
                wword   = {2{bus.wdata[15:0]}};
                lane_en = off[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wword   = bus.wdata;
                lane_en = 4'b1111;
            end
            default: begin
                wword   = bus.wdata;
                lane_en = 4'b0000;
            end
        endcase
    end

    // Select the addressed byte/half of the word and extend it to 32 bits.
    always_comb begin
        rword = mem[widx];
        rbyte = rword[{off, 3'b000} +: 8];
        rhalf = off[1] ? rword[31:16] : rword[15:0];
        case (bus.size)
            2'b00:   rext = {{24{bus.sext & rbyte[7]}}, rbyte};
            2'b01:   rext = {{16{bus.sext & rhalf[15]}}, rhalf};
            default: rext = rword;
        endcase
    end

    // Control FSM plus the response registers; ready is registered so it is
    // low throughout reset even when no sweep follows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RESET;
            ptr          <= '0;
            bus.ready    <= 1'b0;
            bus.rvalid   <= 1'b0;
            bus.misalign <= 1'b0;
            bus.rdata    <= '0;
        end else begin
            bus.rvalid   <= do_load;
            bus.misalign <= accept && err;
            if (do_load) begin
                bus.rdata <= rext;
            end
            case (state)
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state     <= ST_IDLE;
                        bus.ready <= 1'b1;
                    end
                end
                default: begin
                    // An accepted request wins over clear; clear is retried
                    // on the following cycle if still asserted.
                    if (bus.clear && !accept) begin
                        state     <= ST_CLEAR;
                        ptr       <= '0;
                        bus.ready <= 1'b0;
                    end else begin
                        bus.ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array write port: sweep zeroes one word per cycle, stores update lanes.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[ptr] <= '0;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[widx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl with ADDR_W=4 (16 words).
module tb_data_memory_ctrl;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int NBYTES = 64;

    logic       clk;
    logic       reset_n;
    logic [0:0] dbg_state;

    data_memory_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    data_memory_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: {misalign_expected, rdata_expected}.
    logic [32:0] exp_q[$];
    logic [7:0]  ref_mem[NBYTES];
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-array memory, computes response of one accepted access.
    function automatic void model_access(input logic w, input logic [1:0] sz, input logic sx,
                                         input logic [5:0] a, input logic [31:0] d);
        int nb;
        int base;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a);
        if (sz == 2'd3 || (base % nb) != 0) begin
            exp_q.push_back({1'b1, last_rdata});
            return;
        end
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[base + i] = d[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        last_rdata = v;
        exp_q.push_back({1'b0, v});
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    endfunction

    // Monitor: pops one expectation per presented response.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset_n && (bus.rvalid || bus.misalign)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_response: rvalid=%0b misalign=%0b rdata=%h, none expected",
                         bus.rvalid, bus.misalign, bus.rdata);
            end else begin
                e = exp_q.pop_front();
                check("resp_misalign", {31'h0, bus.misalign}, {31'h0, e[32]});
                check("resp_rvalid", {31'h0, bus.rvalid}, {31'h0, ~e[32]});
                check("resp_rdata", bus.rdata, e[31:0]);
            end
        end
    end

    // Driver tasks.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [5:0] a, input logic [31:0] d);
        logic acc;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.size  = sz;
        bus.sext  = sx;
        bus.addr  = a;
        bus.wdata = d;
        acc = bus.ready;
        @(posedge clk);
        if (acc) model_access(w, sz, sx, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    // Called on a negedge; counts negedges with ready low, optionally
    // issuing requests that must be ignored.
    task automatic wait_ready(input bit poke, output int cnt);
        cnt = 0;
        while (!bus.ready && cnt < 200) begin
            cnt++;
            if (poke) begin
                bus.req   = 1'b1;
                bus.we    = 1'($urandom_range(0, 1));
                bus.size  = 2'd2;
                bus.sext  = 1'b0;
                bus.addr  = 6'($urandom_range(0, DEPTH - 1) * 4);
                bus.wdata = $urandom;
            end
            @(negedge clk);
        end
        bus.req = 1'b0;
    endtask

    task automatic start_clear();
        @(negedge clk);
        bus.req   = 1'b0;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic read_all(input logic [31:0] unused);
        for (int i = 0; i < DEPTH; i++) access(1'b0, 2'd2, 1'b0, 6'(i * 4), unused);
    endtask

    int cnt;
    int r;

    initial begin
        reset_n   = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.size  = 2'd0;
        bus.sext  = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.clear = 1'b0;
        last_rdata = 32'h0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'hxx;

        // Reset values and the post-reset sweep length.
        repeat (3) @(negedge clk);
        check("reset_ready", {31'h0, bus.ready}, 32'h0);
        check("reset_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("reset_misalign", {31'h0, bus.misalign}, 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_state_clear", {31'h0, dbg_state}, 32'h1);
        reset_n = 1'b1;
        wait_ready(1'b0, cnt);
        check("reset_sweep_cycles", cnt, DEPTH);
        model_clear();
        read_all(32'h0);

        // Word store then sub-word loads of the same word.
        access(1'b1, 2'd2, 1'b0, 6'h08, 32'h11223344);
        access(1'b0, 2'd0, 1'b1, 6'h0B, 32'h0);
        access(1'b0, 2'd1, 1'b0, 6'h0A, 32'h0);
        access(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);

        // Byte store with negative value; signed/unsigned byte loads.
        access(1'b1, 2'd0, 1'b0, 6'h05, 32'hABCDEF80);
        access(1'b0, 2'd0, 1'b1, 6'h05, 32'h0);
        access(1'b0, 2'd0, 1'b0, 6'h05, 32'h0);
        access(1'b0, 2'd2, 1'b0, 6'h04, 32'h0);
        access(1'b1, 2'd1, 1'b0, 6'h0E, 32'h0000F00D);
        access(1'b0, 2'd1, 1'b1, 6'h0E, 32'h0);

        // Misaligned and reserved-size accesses, then memory unchanged.
        access(1'b1, 2'd1, 1'b0, 6'h03, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 6'h02, 32'h0);
        access(1'b0, 2'd3, 1'b0, 6'h00, 32'h0);
        access(1'b1, 2'd2, 1'b0, 6'h09, 32'hCAFEF00D);
        access(1'b0, 2'd2, 1'b0, 6'h00, 32'h0);
        access(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);
        idle(2);

        // Clear together with an accepted request: request first, clear dropped.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.sext = 1'b0;
        bus.addr = 6'h08; bus.clear = 1'b1;
        r = bus.ready;
        @(posedge clk);
        if (r != 0) model_access(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);
        @(negedge clk);
        bus.req = 1'b0; bus.clear = 1'b0;
        check("clear_with_req_ready", {31'h0, bus.ready}, 32'h1);
        @(negedge clk);
        check("clear_dropped_ready", {31'h0, bus.ready}, 32'h1);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                r = $urandom_range(0, 9);
                access(1'($urandom_range(0, 1)),
                       (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                       1'($urandom_range(0, 1)), 6'($urandom_range(0, NBYTES - 1)), $urandom);
            end
        end
        for (int i = 0; i < DEPTH; i++) access(1'b1, 2'd2, 1'b0, 6'(i * 4), $urandom | 32'h1);
        idle(1);

        // Clear request in IDLE; requests during the sweep are ignored.
        start_clear();
        wait_ready(1'b1, cnt);
        check("clear_sweep_cycles", cnt, DEPTH);
        model_clear();
        read_all(32'h0);

        // Reset in the middle of a sweep: async outputs, full restart.
        access(1'b1, 2'd2, 1'b0, 6'h14, 32'h89ABCDEF);
        access(1'b0, 2'd2, 1'b0, 6'h14, 32'h0);
        idle(2);
        start_clear();
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midsweep_reset_ready", {31'h0, bus.ready}, 32'h0);
        check("midsweep_reset_rdata", bus.rdata, 32'h0);
        check("midsweep_reset_state", {31'h0, dbg_state}, 32'h1);
        last_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_ready(1'b0, cnt);
        check("restart_sweep_cycles", cnt, DEPTH);
        model_clear();
        read_all(32'h0);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
